// File: rtl/router_pkg.sv
// Shared types and constants for the router packet source: FSM states,
// header field layout and the parity error-injection mask.
package router_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HDR,
    ST_PAY,
    ST_PAR,
    ST_GAP
  } state_e;

  localparam logic [1:0] ADDR_ILLEGAL        = 2'd3;
  localparam int         MAX_LEN             = 63;
  localparam int         HDR_LEN_MSB         = 7;
  localparam int         HDR_LEN_LSB         = 2;
  localparam int         HDR_ADDR_MSB        = 1;
  localparam int         HDR_ADDR_LSB        = 0;
  localparam logic [7:0] PARITY_CORRUPT_MASK = 8'h01;

  function automatic logic [7:0] make_hdr(input logic [5:0] len, input logic [1:0] addr);
    logic [7:0] h;
    h = 8'h00;
    h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
    h[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
    return h;
  endfunction

endpackage

// File: rtl/router_src_buf.sv
// Payload store for the packet source: 64x8 array, one write port and one
// asynchronous read port addressed by the next-cycle read pointer.
module router_src_buf
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_inc,
  output logic [7:0] rd_data
);

  localparam int DEPTH = MAX_LEN + 1;

  logic [7:0] mem_q [DEPTH];
  logic [5:0] wr_ptr_q, wr_ptr_d;
  logic [5:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = 6'd0;
      rd_ptr_d = 6'd0;
    end else begin
      if (wr_en)  wr_ptr_d = wr_ptr_q + 6'd1;
      if (rd_inc) rd_ptr_d = rd_ptr_q + 6'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= 6'd0;
      rd_ptr_q <= 6'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  // Look ahead so the registered output stage sees the byte for the next cycle
  assign rd_data = mem_q[rd_ptr_d];

endmodule

// File: rtl/router_pkt_src.sv
// Router input-port packet source: buffers a whole payload, then sends
// header, contiguous payload and trailing parity under busy back-pressure.
module router_pkt_src
  import router_pkg::*;
#(
  parameter int GAP_CYCLES = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_addr,
  input  logic [5:0] req_len,
  input  logic       req_corrupt,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic [7:0] pl_data,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] pkt_data,
  output logic       pkt_done,
  output logic       drop_err
);

  state_e     state_q, state_d;
  logic [7:0] hdr_q, hdr_d;
  logic [7:0] par_q, par_d;
  logic [5:0] cnt_q, cnt_d;
  logic [3:0] gap_q, gap_d;
  logic       corrupt_q, corrupt_d;

  logic       req_ready_q, req_ready_d;
  logic       pl_ready_q, pl_ready_d;
  logic       pkt_valid_q, pkt_valid_d;
  logic [7:0] pkt_data_q, pkt_data_d;
  logic       pkt_done_q, pkt_done_d;
  logic       drop_err_q, drop_err_d;

  logic       accept, illegal, wr_en, rd_inc, clr;
  logic [7:0] rd_data;

  assign accept  = (state_q == ST_IDLE) && req_valid && req_ready_q;
  assign illegal = (req_addr == ADDR_ILLEGAL) || (req_len == 6'd0);
  assign wr_en   = (state_q == ST_LOAD) && pl_valid && pl_ready_q;

  router_src_buf u_buf (
    .clock   (clock),
    .reset   (reset),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_data (pl_data),
    .rd_inc  (rd_inc),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hdr_q       <= 8'h00;
      par_q       <= 8'h00;
      cnt_q       <= 6'd0;
      gap_q       <= 4'd0;
      corrupt_q   <= 1'b0;
      req_ready_q <= 1'b0;
      pl_ready_q  <= 1'b0;
      pkt_valid_q <= 1'b0;
      pkt_data_q  <= 8'h00;
      pkt_done_q  <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      par_q       <= par_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      corrupt_q   <= corrupt_d;
      req_ready_q <= req_ready_d;
      pl_ready_q  <= pl_ready_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_data_q  <= pkt_data_d;
      pkt_done_q  <= pkt_done_d;
      drop_err_q  <= drop_err_d;
    end
  end

  // cnt_q counts bytes still to load in LOAD and bytes still to send in PAY
  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    par_d     = par_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    corrupt_d = corrupt_q;
    rd_inc    = 1'b0;
    clr       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && !illegal) begin
          state_d   = ST_LOAD;
          hdr_d     = make_hdr(req_len, req_addr);
          par_d     = make_hdr(req_len, req_addr);
          cnt_d     = req_len;
          corrupt_d = req_corrupt;
          clr       = 1'b1;
        end
      end
      ST_LOAD: begin
        if (wr_en) begin
          par_d = par_q ^ pl_data;
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (!busy) begin
          state_d = ST_PAY;
          cnt_d   = hdr_q[HDR_LEN_MSB:HDR_LEN_LSB];
        end
      end
      ST_PAY: begin
        if (!busy) begin
          rd_inc = 1'b1;
          cnt_d  = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = ST_PAR;
        end
      end
      ST_PAR: begin
        if (!busy) begin
          state_d = ST_GAP;
          gap_d   = 4'(GAP_CYCLES - 1);
        end
      end
      ST_GAP: begin
        if (gap_q == 4'd0) state_d = ST_IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they register alongside it
  always_comb begin
    req_ready_d = (state_d == ST_IDLE);
    pl_ready_d  = (state_d == ST_LOAD);
    pkt_valid_d = (state_d == ST_HDR) || (state_d == ST_PAY);
    pkt_done_d  = (state_q == ST_PAR) && (state_d == ST_GAP);
    drop_err_d  = accept && illegal;
    case (state_d)
      ST_HDR:  pkt_data_d = hdr_d;
      ST_PAY:  pkt_data_d = rd_data;
      ST_PAR:  pkt_data_d = par_d ^ (corrupt_d ? PARITY_CORRUPT_MASK : 8'h00);
      default: pkt_data_d = 8'h00;
    endcase
  end

  assign req_ready = req_ready_q;
  assign pl_ready  = pl_ready_q;
  assign pkt_valid = pkt_valid_q;
  assign pkt_data  = pkt_data_q;
  assign pkt_done  = pkt_done_q;
  assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_router_pkt_src.sv
// Directed bench for router_pkt_src: expected router bytes are queued when a
// request is driven and compared as the source presents them.
module tb_router_pkt_src;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_addr = 2'd0;
  logic [5:0] req_len = 6'd0;
  logic       req_corrupt = 1'b0;
  logic       pl_valid = 1'b0;
  logic       pl_ready;
  logic [7:0] pl_data = 8'h00;
  logic       busy = 1'b0;
  logic       pkt_valid;
  logic [7:0] pkt_data;
  logic       pkt_done;
  logic       drop_err;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  logic [7:0] pl_buf [64];

  always #5 clock = ~clock;

  router_pkt_src #(.GAP_CYCLES(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .req_corrupt (req_corrupt),
    .pl_valid    (pl_valid),
    .pl_ready    (pl_ready),
    .pl_data     (pl_data),
    .busy        (busy),
    .pkt_valid   (pkt_valid),
    .pkt_data    (pkt_data),
    .pkt_done    (pkt_done),
    .drop_err    (drop_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_basic();
    pl_buf[0] = 8'h11;
    pl_buf[1] = 8'h22;
    pl_buf[2] = 8'h33;
  endtask

  task automatic request(input int addr, input int len, input logic corr);
    int cyc = 0;
    req_valid   = 1'b1;
    req_addr    = 2'(addr);
    req_len     = 6'(len);
    req_corrupt = corr;
    while (req_ready !== 1'b1 && cyc < 100) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic load_pkt(input int addr, input int len, input logic corr, input bit gaps);
    logic [7:0] hdr;
    logic [7:0] par;
    logic       xfer;
    int         i = 0;
    int         cyc = 0;
    hdr = {6'(len), 2'(addr)};
    par = hdr;
    exp_q.push_back({1'b1, hdr});
    for (int k = 0; k < len; k++) begin
      exp_q.push_back({1'b1, pl_buf[k]});
      par = par ^ pl_buf[k];
    end
    if (corr) par = par ^ 8'h01;
    exp_q.push_back({1'b0, par});
    request(addr, len, corr);
    while (i < len && cyc < 300) begin
      pl_valid = !(gaps && (cyc % 3 == 1));
      pl_data  = pl_buf[i];
      xfer     = pl_valid && pl_ready;
      @(posedge clock); #1;
      cyc++;
      if (xfer) i++;
      if (i < len) chk("load_quiet", {31'd0, pkt_valid}, 32'd0);
    end
    pl_valid = 1'b0;
    chk("load_count", i, len);
    if (!gaps) chk("hdr_latency", cyc, len);
    chk("hdr_valid", {31'd0, pkt_valid}, 32'd1);
  endtask

  // n counts transferred bytes: 0 is the header, len+1 the parity byte
  task automatic drain(input int len, input int busy_idx, input int busy_n, input int stop_at);
    int         n = 0;
    int         held = 0;
    int         run = 0;
    int         cyc = 0;
    int         exp_run;
    bit         pb = 1'b0;
    logic [8:0] prev = 9'd0;
    logic [8:0] e;
    logic       presented;
    while (n < len + 2 && cyc < 400) begin
      if (n == stop_at) break;
      busy = (n == busy_idx) && (held < busy_n);
      if (busy) held++;
      @(negedge clock);
      if (pb) chk("busy_hold", {23'd0, pkt_valid, pkt_data}, {23'd0, prev});
      presented = pkt_valid || (n == len + 1);
      if (pkt_valid) run++;
      if (!busy && presented) begin
        chk("queue_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pkt_byte", {23'd0, pkt_valid, pkt_data}, {23'd0, e});
        end
        n++;
      end
      pb   = busy;
      prev = {pkt_valid, pkt_data};
      @(posedge clock); #1;
      cyc++;
    end
    busy = 1'b0;
    if (stop_at >= 0) begin
      chk("stop_reached", n, stop_at);
      return;
    end
    chk("drain_done", n, len + 2);
    chk("pkt_done", {31'd0, pkt_done}, 32'd1);
    exp_run = len + 1 + ((busy_idx >= 0 && busy_idx <= len) ? busy_n : 0);
    chk("valid_run", run, exp_run);
    chk("queue_empty", exp_q.size(), 0);
    @(posedge clock); #1;
    chk("pkt_done_pulse", {31'd0, pkt_done}, 32'd0);
    chk("gap_not_ready", {31'd0, req_ready}, 32'd0);
  endtask

  task automatic illegal_req(input int addr, input int len);
    request(addr, len, 1'b0);
    chk("drop_err", {31'd0, drop_err}, 32'd1);
    chk("drop_ready", {31'd0, req_ready}, 32'd1);
    chk("drop_pl_ready", {31'd0, pl_ready}, 32'd0);
    chk("drop_valid", {31'd0, pkt_valid}, 32'd0);
    @(posedge clock); #1;
    chk("drop_err_pulse", {31'd0, drop_err}, 32'd0);
    chk("drop_pl_ready2", {31'd0, pl_ready}, 32'd0);
    chk("drop_valid2", {31'd0, pkt_valid}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_pl_ready", {31'd0, pl_ready}, 32'd0);
    chk("rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
    chk("rst_pkt_data", {24'd0, pkt_data}, 32'd0);
    chk("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
    chk("rst_drop_err", {31'd0, drop_err}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

    set_basic();
    load_pkt(1, 3, 1'b0, 1'b0);
    drain(3, -1, 0, -1);

    load_pkt(1, 3, 1'b0, 1'b0);
    drain(3, 2, 3, -1);

    illegal_req(3, 5);
    illegal_req(1, 0);

    for (int k = 0; k < 63; k++) pl_buf[k] = 8'(k);
    load_pkt(2, 63, 1'b0, 1'b0);
    drain(63, -1, 0, -1);

    set_basic();
    load_pkt(1, 3, 1'b1, 1'b0);
    drain(3, -1, 0, -1);
    load_pkt(1, 3, 1'b0, 1'b0);
    drain(3, -1, 0, -1);

    for (int k = 0; k < 10; k++) pl_buf[k] = 8'($urandom_range(0, 255));
    load_pkt(0, 10, 1'b0, 1'b1);
    drain(10, 0, 2, -1);
    load_pkt(2, 5, 1'b0, 1'b0);
    drain(5, 6, 2, -1);

    set_basic();
    load_pkt(1, 3, 1'b0, 1'b0);
    drain(3, -1, 0, 2);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("mid_rst_valid", {31'd0, pkt_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, pkt_data}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_rst_done", {31'd0, pkt_done}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("mid_rst_ready_back", {31'd0, req_ready}, 32'd1);
    exp_q.delete();
    load_pkt(1, 3, 1'b0, 1'b0);
    drain(3, -1, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
